// File: rtl/ilv_pkg.sv
// Shared definitions for the WiMAX block interleaver ping-pong scheduler.
package ilv_pkg;

    localparam int NCBPS_QPSK = 192;
    localparam int D_ILV      = 16;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_sel_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/ilv_wr_addr_gen.sv
// First-permutation write address generator: addr = (NCBPS/D)*col + row,
// built incrementally from column/row counters without a multiplier.
module ilv_wr_addr_gen
    import ilv_pkg::*;
#(
    parameter int NCBPS  = NCBPS_QPSK,
    parameter int D      = D_ILV,
    parameter int ADDR_W = 8
)(
    input  logic              clk,
    input  logic              resetN,
    input  logic              flush,
    input  logic              beat,
    output logic [ADDR_W-1:0] addr_w,
    output logic              last_beat
);

    localparam int ROWS  = NCBPS / D;
    localparam int COL_W = (D > 1) ? $clog2(D) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign last_beat = beat && (col == COL_W'(D - 1)) && (row == ROW_W'(ROWS - 1));

    // Advance column first; wrapping a column steps the row and restarts the address at row+1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            col    <= '0;
            row    <= '0;
            addr_w <= '0;
        end else if (flush) begin
            col    <= '0;
            row    <= '0;
            addr_w <= '0;
        end else if (beat) begin
            if (last_beat) begin
                col    <= '0;
                row    <= '0;
                addr_w <= '0;
            end else if (col == COL_W'(D - 1)) begin
                col    <= '0;
                row    <= row + ROW_W'(1);
                addr_w <= ADDR_W'(row) + ADDR_W'(1);
            end else begin
                col    <= col + COL_W'(1);
                addr_w <= addr_w + ADDR_W'(ROWS);
            end
        end
    end

endmodule

// File: rtl/ilv_pp_scheduler.sv
// Ping-pong bank scheduler for the WiMAX block interleaver: permuted writes into
// one bank while the other full bank is read out linearly through a 2-entry buffer.
module ilv_pp_scheduler
    import ilv_pkg::*;
#(
    parameter int NCBPS  = NCBPS_QPSK,
    parameter int D      = D_ILV,
    parameter int ADDR_W = 8
)(
    input  logic              clk,
    input  logic              resetN,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              d_in,
    output logic              ready_out,
    output logic              wren_A,
    output logic              wren_B,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wrdata,
    output logic              rden_A,
    output logic              rden_B,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic              q_A,
    input  logic              q_B,
    output logic              valid_out,
    output logic              q,
    input  logic              ready_in,
    output logic [1:0]        bank_full
);

    wr_state_t         w_state, w_state_nxt;
    rd_state_t         r_state, r_state_nxt;
    bank_sel_t         w_sel, r_sel, rd_bank;
    logic [1:0]        full, full_nxt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_pend;
    logic              beat, last_beat;
    logic              issue, drain_done, pop, push, push_bit;
    logic [1:0]        occ;
    logic [1:0]        fifo_mem;
    logic              fifo_wr_ptr, fifo_rd_ptr;

    assign ready_out  = resetN && !flush && !full[w_sel];
    assign beat       = valid_in && ready_out;
    assign pop        = valid_out && ready_in;
    assign issue      = full[r_sel] && !flush &&
                        (({1'b0, occ} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));
    assign drain_done = issue && (rd_cnt == ADDR_W'(NCBPS - 1));
    assign push       = rd_pend;
    assign push_bit   = (rd_bank == BANK_A) ? q_A : q_B;
    assign valid_out  = (occ != 2'd0);
    assign q          = valid_out && fifo_mem[fifo_rd_ptr];
    assign bank_full  = full;
    assign rdaddress  = rd_cnt;

    ilv_wr_addr_gen #(
        .NCBPS  (NCBPS),
        .D      (D),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (flush),
        .beat      (beat),
        .addr_w    (wraddress),
        .last_beat (last_beat)
    );

    // Write FSM: steer the accepted bit to the bank being filled and track fill progress.
    always_comb begin
        w_state_nxt = w_state;
        wren_A      = 1'b0;
        wren_B      = 1'b0;
        wrdata      = 1'b0;
        if (beat) begin
            wren_A = (w_sel == BANK_A);
            wren_B = (w_sel == BANK_B);
            wrdata = d_in;
        end
        case (w_state)
            W_IDLE:  if (beat && !last_beat) w_state_nxt = W_FILL;
            W_FILL:  if (beat && last_beat)  w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        if (flush) w_state_nxt = W_IDLE;
    end

    // Read FSM: issue linear reads of the full bank while the output buffer has room.
    always_comb begin
        r_state_nxt = r_state;
        rden_A      = issue && (r_sel == BANK_A);
        rden_B      = issue && (r_sel == BANK_B);
        case (r_state)
            R_IDLE:  if (full[r_sel] && !drain_done) r_state_nxt = R_DRAIN;
            R_DRAIN: if (drain_done)                 r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
        if (flush) r_state_nxt = R_IDLE;
    end

    // Full flags: the write side sets its bank on the last beat, the read side clears its bank after the last read.
    always_comb begin
        full_nxt = full;
        if (beat && last_beat) full_nxt[w_sel] = 1'b1;
        if (drain_done)        full_nxt[r_sel] = 1'b0;
    end

    // Bank bookkeeping and read counter state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            w_sel   <= BANK_A;
            r_sel   <= BANK_A;
            rd_bank <= BANK_A;
            full    <= 2'b00;
            rd_cnt  <= '0;
            rd_pend <= 1'b0;
        end else if (flush) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            w_sel   <= BANK_A;
            r_sel   <= BANK_A;
            rd_bank <= BANK_A;
            full    <= 2'b00;
            rd_cnt  <= '0;
            rd_pend <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            full    <= full_nxt;
            rd_pend <= issue;
            rd_bank <= r_sel;
            if (beat && last_beat) w_sel <= other_bank(w_sel);
            if (drain_done) begin
                r_sel  <= other_bank(r_sel);
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + ADDR_W'(1);
            end
        end
    end

    // Two-entry output FIFO fed by the bank read data one cycle after each issue.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            occ         <= 2'd0;
            fifo_mem    <= 2'b00;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else if (flush) begin
            occ         <= 2'd0;
            fifo_mem    <= 2'b00;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wr_ptr] <= push_bit;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    a_wren_excl: assert property (@(posedge clk) disable iff (!resetN) !(wren_A && wren_B));
    a_rden_excl: assert property (@(posedge clk) disable iff (!resetN) !(rden_A && rden_B));
    a_bank_a_rw: assert property (@(posedge clk) disable iff (!resetN) !(wren_A && rden_A));
    a_bank_b_rw: assert property (@(posedge clk) disable iff (!resetN) !(wren_B && rden_B));
    a_occ_max:   assert property (@(posedge clk) disable iff (!resetN) occ != 2'd3);

endmodule

// File: tb/tb_ilv_pp_scheduler.sv
// Directed bench for the interleaver ping-pong scheduler with behavioural bank RAMs.
module tb_ilv_pp_scheduler;

    logic       clk = 1'b0;
    logic       resetN, flush, valid_in, d_in, ready_in;
    logic       q_A = 1'b0;
    logic       q_B = 1'b0;
    logic       ready_out, wren_A, wren_B, wrdata, rden_A, rden_B, valid_out, q;
    logic [7:0] wraddress, rdaddress;
    logic [1:0] bank_full;

    logic memA [256];
    logic memB [256];

    int checks = 0;
    int failures = 0;
    int acceptedCnt, popped, rdenCnt, wrenACnt, wrenBCnt, wrErrs, outErrs, readyLow;
    int addrLog [192];
    bit inBuf [192];
    bit expQ [$];

    always #5 clk = ~clk;

    ilv_pp_scheduler dut (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (flush),
        .valid_in  (valid_in),
        .d_in      (d_in),
        .ready_out (ready_out),
        .wren_A    (wren_A),
        .wren_B    (wren_B),
        .wraddress (wraddress),
        .wrdata    (wrdata),
        .rden_A    (rden_A),
        .rden_B    (rden_B),
        .rdaddress (rdaddress),
        .q_A       (q_A),
        .q_B       (q_B),
        .valid_out (valid_out),
        .q         (q),
        .ready_in  (ready_in),
        .bank_full (bank_full)
    );

    // Bank RAMs with one cycle of read latency
    always @(posedge clk) begin
        if (wren_A) memA[wraddress] <= wrdata;
        if (wren_B) memB[wraddress] <= wrdata;
        if (rden_A) q_A <= memA[rdaddress];
        if (rden_B) q_B <= memB[rdaddress];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int expAddr(input int k);
        return 12 * (k % 16) + k / 16;
    endfunction

    task automatic applyStimulus(input bit vin, input bit din, input bit rin);
        valid_in = vin;
        d_in     = din;
        ready_in = rin;
    endtask

    task automatic resetModel();
        expQ.delete();
        acceptedCnt = 0; popped = 0; rdenCnt = 0; wrenACnt = 0; wrenBCnt = 0;
        wrErrs = 0; outErrs = 0; readyLow = 0;
    endtask

    task automatic pushBlock();
        for (int n = 0; n < 192; n++)
            for (int k = 0; k < 192; k++)
                if (expAddr(k) == n) expQ.push_back(inBuf[k]);
    endtask

    // Score one cycle of DUT activity against the reference model
    task automatic observe();
        int k, blk;
        if (rden_A || rden_B) rdenCnt++;
        if (wren_A) wrenACnt++;
        if (wren_B) wrenBCnt++;
        if (!ready_out) readyLow++;
        if (valid_in && ready_out) begin
            k   = acceptedCnt % 192;
            blk = acceptedCnt / 192;
            if (blk == 0) addrLog[k] = int'(wraddress);
            if ((blk % 2) == 0) begin
                if (!(wren_A && !wren_B)) wrErrs++;
            end else begin
                if (!(wren_B && !wren_A)) wrErrs++;
            end
            if (int'(wraddress) != expAddr(k)) wrErrs++;
            if (wrdata !== d_in) wrErrs++;
            inBuf[k] = d_in;
            acceptedCnt++;
            if (k == 191) pushBlock();
        end else if (wren_A || wren_B) begin
            wrErrs++;
        end
        if (valid_out && ready_in) begin
            popped++;
            if (expQ.size() == 0) outErrs++;
            else if (q !== expQ.pop_front()) outErrs++;
        end
    endtask

    task automatic stepOne(input bit vin, input bit rin);
        applyStimulus(vin, 1'($urandom), rin);
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0);
        flush  = 1'b0;
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        resetModel();
    endtask

    initial begin
        bit found;
        bit qHead;
        resetN = 1'b0;
        flush  = 1'b0;
        applyStimulus(0, 0, 0);
        resetModel();

        // Reset state
        #2;
        checkOutput("rst_ready_out", ready_out, 0);
        checkOutput("rst_bank_full", bank_full, 0);
        checkOutput("rst_valid_out", valid_out, 0);
        checkOutput("rst_enables", {wren_A, wren_B, rden_A, rden_B}, 0);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("rel_ready_out", ready_out, 1);
        checkOutput("rel_wraddress", wraddress, 0);

        // Write-address sequence for one block
        resetDut();
        for (int c = 0; c < 192; c++) stepOne(1, 0);
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("wa_k0", addrLog[0], 0);
        checkOutput("wa_k1", addrLog[1], 12);
        checkOutput("wa_k15", addrLog[15], 180);
        checkOutput("wa_k16", addrLog[16], 1);
        checkOutput("wa_k17", addrLog[17], 13);
        checkOutput("wa_k191", addrLog[191], 191);
        checkOutput("wa_wrenA_cnt", wrenACnt, 192);
        checkOutput("wa_wrenB_cnt", wrenBCnt, 0);
        checkOutput("wa_bank_full", bank_full, 2'b01);
        checkOutput("wa_wr_errs", wrErrs, 0);

        // Full-rate ping-pong over four blocks
        resetDut();
        for (int c = 0; c < 1200 && popped < 768; c++) stepOne(acceptedCnt < 768, 1);
        checkOutput("pp_ready_low", readyLow, 0);
        checkOutput("pp_popped", popped, 768);
        checkOutput("pp_out_errs", outErrs, 0);
        checkOutput("pp_wr_errs", wrErrs, 0);
        checkOutput("pp_wrenA_cnt", wrenACnt, 384);
        checkOutput("pp_wrenB_cnt", wrenBCnt, 384);

        // Backpressure with ready_in held low
        resetDut();
        for (int c = 0; c < 400; c++) stepOne(1, 0);
        applyStimulus(1, 0, 0);
        #1;
        qHead = (expQ.size() > 0) ? expQ[0] : 1'b0;
        checkOutput("bp_accepted", acceptedCnt, 384);
        checkOutput("bp_ready_out", ready_out, 0);
        checkOutput("bp_bank_full", bank_full, 2'b11);
        checkOutput("bp_rden_cnt", rdenCnt, 2);
        checkOutput("bp_valid_out", valid_out, 1);
        checkOutput("bp_q_head", q, qHead);
        @(negedge clk);
        for (int c = 0; c < 5; c++) stepOne(1, 0);
        #1;
        checkOutput("bp_q_stable", q, qHead);
        checkOutput("bp_rden_cnt_hold", rdenCnt, 2);

        // Random stall on both sides
        resetDut();
        for (int c = 0; c < 4000 && popped < 384; c++)
            stepOne((acceptedCnt < 384) && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1);
        checkOutput("rs_popped", popped, 384);
        checkOutput("rs_out_errs", outErrs, 0);
        checkOutput("rs_wr_errs", wrErrs, 0);
        checkOutput("rs_leftover", expQ.size(), 0);

        // Flush mid-block
        resetDut();
        for (int c = 0; c < 100; c++) stepOne(1, 1);
        applyStimulus(1, 1, 1);
        flush = 1'b1;
        #1;
        checkOutput("fl_ready_during", ready_out, 0);
        checkOutput("fl_wren_during", {wren_A, wren_B}, 0);
        @(negedge clk);
        flush = 1'b0;
        applyStimulus(0, 0, 1);
        #1;
        checkOutput("fl_bank_full", bank_full, 0);
        checkOutput("fl_valid_out", valid_out, 0);
        checkOutput("fl_ready_out", ready_out, 1);
        resetModel();
        @(negedge clk);
        for (int c = 0; c < 600 && popped < 192; c++) stepOne(acceptedCnt < 192, 1);
        checkOutput("fl_first_addr", addrLog[0], 0);
        checkOutput("fl_wrenA_cnt", wrenACnt, 192);
        checkOutput("fl_wr_errs", wrErrs, 0);
        checkOutput("fl_popped", popped, 192);
        checkOutput("fl_out_errs", outErrs, 0);

        // Reset in the middle of draining bank A
        resetDut();
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            applyStimulus(acceptedCnt < 192, 1'($urandom), 1);
            #1;
            if (rden_A && rdaddress == 8'd50) found = 1'b1;
            else begin
                observe();
                @(negedge clk);
            end
        end
        checkOutput("rd_reached_50", found, 1);
        resetN = 1'b0;
        #1;
        checkOutput("rd_ctrl_zero", {ready_out, wren_A, wren_B, wrdata, rden_A, rden_B, valid_out, q}, 0);
        checkOutput("rd_bus_zero", {bank_full, wraddress, rdaddress}, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        resetModel();
        applyStimulus(1, 1, 0);
        #1;
        checkOutput("rd_restart_bank", {wren_A, wren_B}, 2'b10);
        checkOutput("rd_restart_addr", wraddress, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ilv_pp_scheduler.md
Name: ilv_pp_scheduler

Overview:
- Sequences the two 192-bit ping-pong bit RAMs of the WiMAX block interleaver (bank A, bank B).
- Write side: accepts one coded bit per valid_in/ready_out beat and writes it at the 802.16 first-permutation address (QPSK, Ncbps=192, d=16).
- Read side: streams the filled bank out linearly through a 2-entry output buffer with valid_out/ready_in backpressure.
- Sits between the randomizer/FEC stream and the modulator mapper.

Parameters:
- NCBPS, 192, coded bits per block (bank depth).
- D, 16, interleaver column count; NCBPS % D == 0 required.
- ADDR_W, 8, RAM address width; must satisfy 2**ADDR_W >= NCBPS.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: empties both banks and the output buffer.
- valid_in  in  1  upstream bit valid.
- d_in  in  1  upstream coded bit.
- ready_out  out  1  scheduler can accept d_in this cycle.
- wren_A, wren_B  out  1  bank write enables; never both high.
- wraddress  out  ADDR_W  write address, shared by both banks.
- wrdata  out  1  write data (= d_in).
- rden_A, rden_B  out  1  bank read enables; never both high.
- rdaddress  out  ADDR_W  read address, shared by both banks.
- q_A, q_B  in  1  bank read data, valid 1 cycle after rden.
- valid_out  out  1  downstream bit valid.
- q  out  1  interleaved bit.
- ready_in  in  1  downstream accepts q.
- bank_full  out  2  [0]=A full, [1]=B full (status).

Behaviour:
- Reset and flush: all outputs 0, all counters 0, w_sel=A, r_sel=A, full flags 0, output buffer empty. Flush has priority over every other event in its cycle.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side FSM, states W_IDLE and W_FILL:
  - ready_out = !full[w_sel] && !flush.
  - Write beat when valid_in && ready_out: wren_<w_sel>=1, wraddress=addr_w, wrdata=d_in, all in the same cycle.
- Write address generation with counters col (0..D-1), row (0..NCBPS/D-1):
  - addr_w = (NCBPS/D)*col + row.
  - Produced incrementally: on each beat, if col==D-1 then col=0, row++, addr_w=row+1; else col++, addr_w+=NCBPS/D. No multiplier.
- Block end: on the 192nd beat (col==D-1 && row==NCBPS/D-1), full[w_sel] sets, w_sel toggles, and col, row and addr_w clear, all on the next edge.
- Read side FSM, states R_IDLE and R_DRAIN:
  - Starts when full[r_sel]=1.
  - Issues rden_<r_sel> with rdaddress=rd_cnt (0..NCBPS-1 linear) when occ + rd_pend - pop < 2.
  - occ = output buffer occupancy (0..2); pop = valid_out && ready_in; rd_pend = read issued in the previous cycle.
- End of drain: after issuing address NCBPS-1, full[r_sel] clears on the next edge and r_sel toggles. Write side may begin refilling that bank in the following cycle.
- Read data capture: q_<bank of pending read> enters the output buffer 1 cycle after issue. The read-side bank tag is registered, so q selection does not depend on the current r_sel.
- Output buffer: 2-entry FIFO. valid_out = occ!=0; q = head entry. Throughput is 1 bit/cycle with ready_in held high. First valid_out appears 2 cycles after the first rden of a bank.
- Simultaneous events:
  - A write to one bank and a read of the other in the same cycle is legal and required for full rate.
  - Setting full on one bank and clearing it on the other in the same edge is independent.
  - A bank is never written while full or read while not full.
- Backpressure: with ready_in low, at most 2 bits are buffered and reads stall with rd_cnt held. Once both banks are full, ready_out drops.
- Reset mid-operation: asynchronous; all state is lost and no partial block is resumed.
- Assertions: wren_A && wren_B never; rden_A && rden_B never; wren_X && rden_X never; occ <= 2.

Decomposition:
- Shared package ilv_pkg:
  - NCBPS_QPSK=192, D_ILV=16.
  - Typedef bank_sel_t {BANK_A, BANK_B}.
  - Typedefs for the write FSM state and the read FSM state.
- One natural sub-module: ilv_wr_addr_gen, containing the col/row/addr_w counters, the beat input, the last-beat output and flush.

Test Plan:
- Write-address check: a single block with valid_in held high gives wraddress for beats k=0,1,15,16,17,191 equal to 0,12,180,1,13,191. wren_A is high for 192 cycles, then bank_full=2'b01.
- Full-rate ping-pong: 4 blocks, with valid_in and ready_in always 1. ready_out never drops after reset. Output bit n of block b equals input bit at k where 12*(k%16)+k/16==n. Writes alternate A, B, A, B.
- Backpressure: hold ready_in=0 from start. After 384 accepted bits, ready_out=0 and bank_full=2'b11. Only 2 rden pulses are issued and valid_out=1 is held with the first bit stable.
- Random stall: valid_in and ready_in each random at 50%. Output stream equals the reference permutation with no loss or duplication, and the occ<=2 assertion holds.
- Flush mid-block: flush after 100 bits of block 0. On the next cycle bank_full=0, valid_out=0 and ready_out=1. The next 192 bits write starting at wraddress=0 in bank A.
- Reset mid-drain: resetN=0 while reading bank A at rd_cnt=50. All outputs go 0 immediately, and after release the first accepted bit writes bank A address 0.
